// File: rtl/pcie_tx_arbiter.sv
// Packet-atomic round-robin merge of the PIO completion source and the Ethernet
// TLP source onto the PCIe core transmit stream, with a registered output stage.
module pcie_tx_arbiter #(
  parameter int unsigned C_DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter logic [5:0]  BUF_AV_MIN   = 6'd2
) (
  input  logic                    pcie_clk,
  input  logic                    pcie_rst_n,

  input  logic                    pio_tx_tvalid,
  output logic                    pio_tx_tready,
  input  logic                    pio_tx_tlast,
  input  logic [KEEP_WIDTH-1:0]   pio_tx_tkeep,
  input  logic [C_DATA_WIDTH-1:0] pio_tx_tdata,
  input  logic [3:0]              pio_tx_tuser,

  input  logic                    eth_tx_tvalid,
  output logic                    eth_tx_tready,
  input  logic                    eth_tx_tlast,
  input  logic [KEEP_WIDTH-1:0]   eth_tx_tkeep,
  input  logic [C_DATA_WIDTH-1:0] eth_tx_tdata,
  input  logic [3:0]              eth_tx_tuser,

  input  logic [5:0]              tx_buf_av,
  input  logic                    s_axis_tx_tready,
  output logic                    s_axis_tx_tvalid,
  output logic                    s_axis_tx_tlast,
  output logic [KEEP_WIDTH-1:0]   s_axis_tx_tkeep,
  output logic [C_DATA_WIDTH-1:0] s_axis_tx_tdata,
  output logic [3:0]              s_axis_tx_tuser,

  output logic [31:0]             pio_pkt_cnt,
  output logic [31:0]             eth_pkt_cnt
);

  localparam int unsigned USER_W = 4;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_PIO, ST_ETH} state_e;
  typedef enum logic {SRC_PIO, SRC_ETH} src_e;

  typedef struct packed {
    logic                    last;
    logic [KEEP_WIDTH-1:0]   keep;
    logic [C_DATA_WIDTH-1:0] data;
    logic [USER_W-1:0]       user;
  } beat_t;

  state_e             state_q, state_d;
  src_e               last_grant_q, last_grant_d;
  logic               ovalid_q, ovalid_d;
  beat_t              oreg_q, oreg_d;
  logic [CNT_W-1:0]   pio_cnt_q, pio_cnt_d;
  logic [CNT_W-1:0]   eth_cnt_q, eth_cnt_d;

  logic               load_en_c;
  logic               pio_rdy_c;
  logic               eth_rdy_c;
  beat_t              pio_beat_c;
  beat_t              eth_beat_c;

  assign pio_beat_c = '{last: pio_tx_tlast, keep: pio_tx_tkeep,
                        data: pio_tx_tdata, user: pio_tx_tuser};
  assign eth_beat_c = '{last: eth_tx_tlast, keep: eth_tx_tkeep,
                        data: eth_tx_tdata, user: eth_tx_tuser};

  // Arbitration, source handshake and output-register next state
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ovalid_d     = ovalid_q;
    oreg_d       = oreg_q;
    pio_cnt_d    = pio_cnt_q;
    eth_cnt_d    = eth_cnt_q;
    pio_rdy_c    = 1'b0;
    eth_rdy_c    = 1'b0;
    load_en_c    = !ovalid_q || s_axis_tx_tready;

    if (ovalid_q && s_axis_tx_tready) begin
      ovalid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // No tready here: this cycle is the inter-packet arbitration bubble
        if (tx_buf_av >= BUF_AV_MIN) begin
          if (pio_tx_tvalid && eth_tx_tvalid) begin
            if (last_grant_q == SRC_ETH) begin
              state_d      = ST_PIO;
              last_grant_d = SRC_PIO;
            end else begin
              state_d      = ST_ETH;
              last_grant_d = SRC_ETH;
            end
          end else if (pio_tx_tvalid) begin
            state_d      = ST_PIO;
            last_grant_d = SRC_PIO;
          end else if (eth_tx_tvalid) begin
            state_d      = ST_ETH;
            last_grant_d = SRC_ETH;
          end
        end
      end
      ST_PIO: begin
        pio_rdy_c = load_en_c;
        if (pio_tx_tvalid && load_en_c) begin
          ovalid_d = 1'b1;
          oreg_d   = pio_beat_c;
          if (pio_tx_tlast) begin
            state_d   = ST_IDLE;
            pio_cnt_d = pio_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ETH: begin
        eth_rdy_c = load_en_c;
        if (eth_tx_tvalid && load_en_c) begin
          ovalid_d = 1'b1;
          oreg_d   = eth_beat_c;
          if (eth_tx_tlast) begin
            state_d   = ST_IDLE;
            eth_cnt_d = eth_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= SRC_ETH;
      ovalid_q     <= 1'b0;
      oreg_q       <= '0;
      pio_cnt_q    <= '0;
      eth_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ovalid_q     <= ovalid_d;
      oreg_q       <= oreg_d;
      pio_cnt_q    <= pio_cnt_d;
      eth_cnt_q    <= eth_cnt_d;
    end
  end

  assign pio_tx_tready    = pio_rdy_c;
  assign eth_tx_tready    = eth_rdy_c;
  assign s_axis_tx_tvalid = ovalid_q;
  assign s_axis_tx_tlast  = oreg_q.last;
  assign s_axis_tx_tkeep  = oreg_q.keep;
  assign s_axis_tx_tdata  = oreg_q.data;
  assign s_axis_tx_tuser  = oreg_q.user;
  assign pio_pkt_cnt      = pio_cnt_q;
  assign eth_pkt_cnt      = eth_cnt_q;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Bench for pcie_tx_arbiter: a transaction-level ownership model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_pcie_tx_arbiter;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic [3:0]  u;
    logic        l;
  } tb_beat_t;

  logic        pcie_clk = 1'b0;
  logic        pcie_rst_n = 1'b1;
  logic        pio_v = 1'b0, eth_v = 1'b0;
  tb_beat_t    pio_b = '0, eth_b = '0;
  logic [5:0]  tx_buf_av = 6'd10;
  logic        core_rdy = 1'b1;

  logic        pio_tx_tready, eth_tx_tready;
  logic        s_axis_tx_tvalid, s_axis_tx_tlast;
  logic [7:0]  s_axis_tx_tkeep;
  logic [63:0] s_axis_tx_tdata;
  logic [3:0]  s_axis_tx_tuser;
  logic [31:0] pio_pkt_cnt, eth_pkt_cnt;

  pcie_tx_arbiter dut (
    .pcie_clk(pcie_clk), .pcie_rst_n(pcie_rst_n),
    .pio_tx_tvalid(pio_v), .pio_tx_tready(pio_tx_tready), .pio_tx_tlast(pio_b.l),
    .pio_tx_tkeep(pio_b.k), .pio_tx_tdata(pio_b.d), .pio_tx_tuser(pio_b.u),
    .eth_tx_tvalid(eth_v), .eth_tx_tready(eth_tx_tready), .eth_tx_tlast(eth_b.l),
    .eth_tx_tkeep(eth_b.k), .eth_tx_tdata(eth_b.d), .eth_tx_tuser(eth_b.u),
    .tx_buf_av(tx_buf_av), .s_axis_tx_tready(core_rdy),
    .s_axis_tx_tvalid(s_axis_tx_tvalid), .s_axis_tx_tlast(s_axis_tx_tlast),
    .s_axis_tx_tkeep(s_axis_tx_tkeep), .s_axis_tx_tdata(s_axis_tx_tdata),
    .s_axis_tx_tuser(s_axis_tx_tuser),
    .pio_pkt_cnt(pio_pkt_cnt), .eth_pkt_cnt(eth_pkt_cnt)
  );

  always #5 pcie_clk = ~pcie_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Beat encoding: source tag, packet id and beat index are all visible in tdata
  function automatic tb_beat_t mk(input int s, input int id, input int b, input int n);
    tb_beat_t r;
    r.d = {8'(s + 1), 8'(id), 40'h0, 8'(b)};
    r.k = (b == n - 1) ? 8'h0F : 8'hFF;
    r.u = 4'(b) ^ ((s == 1) ? 4'h8 : 4'h0);
    r.l = (b == n - 1);
    return r;
  endfunction

  tb_beat_t pio_q[$];
  tb_beat_t eth_q[$];
  tb_beat_t out_log[$];
  logic     flush = 1'b0;

  task automatic push_pkt(input int s, input int id, input int n);
    for (int b = 0; b < n; b++) begin
      if (s == 0) pio_q.push_back(mk(s, id, b, n));
      else        eth_q.push_back(mk(s, id, b, n));
    end
  endtask

  // Source drivers: present queue heads, pop on observed handshake
  initial begin
    logic hs_p, hs_e;
    forever begin
      @(negedge pcie_clk);
      hs_p = pio_v && pio_tx_tready;
      hs_e = eth_v && eth_tx_tready;
      @(posedge pcie_clk);
      #2;
      if (flush) begin
        pio_q.delete();
        eth_q.delete();
      end else begin
        if (hs_p && pio_q.size() > 0) void'(pio_q.pop_front());
        if (hs_e && eth_q.size() > 0) void'(eth_q.pop_front());
      end
      pio_v = (pio_q.size() > 0);
      pio_b = (pio_q.size() > 0) ? pio_q[0] : '0;
      eth_v = (eth_q.size() > 0);
      eth_b = (eth_q.size() > 0) ? eth_q[0] : '0;
    end
  end

  // Reference model: owner of the output (-1 = nobody), last winner, one output slot
  int          m_owner = -1;
  int          m_last  = 1;
  int          m_acc;
  logic        m_ov = 1'b0;
  tb_beat_t    m_ob = '0;
  logic [31:0] m_cnt [2] = '{32'd0, 32'd0};
  logic        m_preset = 1'b0;
  logic        cnt_chk_en = 1'b1;

  function automatic logic m_rdy(input int s);
    return (m_owner == s) && (!m_ov || core_rdy);
  endfunction

  always @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      m_owner  = -1;
      m_last   = 1;
      m_ov     = 1'b0;
      m_ob     = '0;
      m_cnt[0] = 32'd0;
      m_cnt[1] = 32'd0;
    end else begin
      m_acc = -1;
      if (pio_v && m_rdy(0)) m_acc = 0;
      else if (eth_v && m_rdy(1)) m_acc = 1;
      if (m_owner < 0 && tx_buf_av >= 6'd2) begin
        if (pio_v && eth_v) m_owner = 1 - m_last;
        else if (pio_v)     m_owner = 0;
        else if (eth_v)     m_owner = 1;
        if (m_owner >= 0) m_last = m_owner;
      end
      if (m_acc >= 0) begin
        m_ov = 1'b1;
        m_ob = (m_acc == 0) ? pio_b : eth_b;
        if (m_ob.l) begin
          m_cnt[m_acc] = m_cnt[m_acc] + 32'd1;
          m_owner = -1;
        end
      end else if (core_rdy) begin
        m_ov = 1'b0;
      end
      if (m_preset) m_cnt[1] = 32'hFFFF_FFFE;
    end
  end

  // Per-cycle compare against the model plus AXIS stall rules
  logic     prev_stall = 1'b0;
  tb_beat_t prev_out = '0;
  always @(negedge pcie_clk) begin
    tb_beat_t cur;
    cur = '{d: s_axis_tx_tdata, k: s_axis_tx_tkeep, u: s_axis_tx_tuser, l: s_axis_tx_tlast};
    chk("tvalid", 64'(s_axis_tx_tvalid), 64'(m_ov));
    if (m_ov) begin
      chk("tdata", cur.d, m_ob.d);
      chk("tlast_tkeep_tuser", 64'({cur.l, cur.k, cur.u}), 64'({m_ob.l, m_ob.k, m_ob.u}));
    end
    chk("pio_tready", 64'(pio_tx_tready), 64'(m_rdy(0)));
    chk("eth_tready", 64'(eth_tx_tready), 64'(m_rdy(1)));
    if (cnt_chk_en) begin
      chk("pio_pkt_cnt", 64'(pio_pkt_cnt), 64'(m_cnt[0]));
      chk("eth_pkt_cnt", 64'(eth_pkt_cnt), 64'(m_cnt[1]));
    end
    if (prev_stall && pcie_rst_n) begin
      chk("hold_valid", 64'(s_axis_tx_tvalid), 64'd1);
      chk("hold_beat", 64'(cur), 64'(prev_out));
    end
    if (s_axis_tx_tvalid && !core_rdy)
      chk("stall_tready", 64'({pio_tx_tready, eth_tx_tready}), 64'd0);
    prev_stall = pcie_rst_n && s_axis_tx_tvalid && !core_rdy;
    prev_out   = cur;
    if (pcie_rst_n && s_axis_tx_tvalid && core_rdy) out_log.push_back(cur);
  end

  task automatic cyc();
    @(posedge pcie_clk);
    #1;
  endtask

  task automatic wait_log(input int n, input int budget, input string nm);
    int i = 0;
    while (out_log.size() < n && i < budget) begin
      @(negedge pcie_clk);
      #1;
      i++;
    end
    chk({"timeout_", nm}, 64'(out_log.size() >= n), 64'd1);
  endtask

  task automatic do_reset();
    pcie_rst_n = 1'b0;
    flush = 1'b1;
    cyc();
    cyc();
    flush = 1'b0;
    out_log.delete();
    pcie_rst_n = 1'b1;
    cyc();
  endtask

  int rdy_exp [6] = '{0, 1, 1, 1, 0, 0};
  int vld_exp [6] = '{0, 0, 1, 1, 1, 0};
  int bp_pat  [14] = '{1, 1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1};

  initial begin
    #1 pcie_rst_n = 1'b0;
    #1;
    chk("rst_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    chk("rst_tready", 64'({pio_tx_tready, eth_tx_tready}), 64'd0);
    chk("rst_cnt", {pio_pkt_cnt, eth_pkt_cnt}, 64'd0);
    do_reset();

    // PIO only, 3 beats: one IDLE cycle, 3 ready cycles, outputs one cycle later
    push_pkt(0, 1, 3);
    for (int i = 0; i < 6; i++) begin
      @(negedge pcie_clk);
      chk("t1_pio_tready", 64'(pio_tx_tready), 64'(rdy_exp[i]));
      chk("t1_tvalid", 64'(s_axis_tx_tvalid), 64'(vld_exp[i]));
    end
    #1;
    chk("t1_cnt", 64'(pio_pkt_cnt), 64'd1);
    chk("t1_nbeats", 64'(out_log.size()), 64'd3);
    chk("t1_b0", out_log[0].d, 64'h0101_0000_0000_0000);
    chk("t1_b2", out_log[2].d, 64'h0101_0000_0000_0002);
    chk("t1_b2_keep", 64'(out_log[2].k), 64'h0F);

    // Both sources streaming 2-beat packets: strict alternation starting with PIO
    do_reset();
    for (int p = 0; p < 4; p++) begin
      push_pkt(0, p, 2);
      push_pkt(1, p, 2);
    end
    wait_log(16, 300, "t2");
    for (int k = 0; k < 8; k++)
      for (int b = 0; b < 2; b++)
        chk("t2_order", out_log[2*k+b].d, mk(k % 2, k / 2, b, 2).d);
    chk("t2_cnts", {pio_pkt_cnt, eth_pkt_cnt}, {32'd4, 32'd4});

    // Backpressure on a 4-beat ETH packet
    do_reset();
    push_pkt(1, 5, 4);
    for (int i = 0; i < 14; i++) begin
      core_rdy = 1'(bp_pat[i]);
      cyc();
    end
    core_rdy = 1'b1;
    wait_log(4, 50, "t3");
    chk("t3_nbeats", 64'(out_log.size()), 64'd4);
    for (int b = 0; b < 4; b++)
      chk("t3_beat", out_log[b].d, 64'h0205_0000_0000_0000 | 64'(b));
    chk("t3_cnt", 64'(eth_pkt_cnt), 64'd1);

    // Buffer gating, single-beat packet
    do_reset();
    tx_buf_av = 6'd1;
    push_pkt(0, 7, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge pcie_clk);
      chk("t4_gated_tready", 64'(pio_tx_tready), 64'd0);
      chk("t4_gated_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    end
    cyc();
    tx_buf_av = 6'd2;
    @(negedge pcie_clk);
    chk("t4_idle_tready", 64'(pio_tx_tready), 64'd0);
    @(negedge pcie_clk);
    chk("t4_grant_tready", 64'(pio_tx_tready), 64'd1);
    wait_log(1, 20, "t4");
    chk("t4_cnt", 64'(pio_pkt_cnt), 64'd1);
    tx_buf_av = 6'd10;

    // Asynchronous reset mid-packet, then PIO must win the first contention
    do_reset();
    push_pkt(0, 9, 5);
    wait_log(2, 20, "t5");
    #1 pcie_rst_n = 1'b0;
    #1;
    chk("t5_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    chk("t5_cnt", {pio_pkt_cnt, eth_pkt_cnt}, 64'd0);
    do_reset();
    push_pkt(1, 1, 1);
    push_pkt(0, 2, 1);
    wait_log(2, 30, "t5b");
    chk("t5_first", out_log[0].d, 64'h0102_0000_0000_0000);
    chk("t5_second", out_log[1].d, 64'h0201_0000_0000_0000);

    // Counter wrap
    do_reset();
    cnt_chk_en = 1'b0;
    force dut.eth_cnt_q = 32'hFFFF_FFFE;
    m_preset = 1'b1;
    cyc();
    release dut.eth_cnt_q;
    m_preset = 1'b0;
    cnt_chk_en = 1'b1;
    push_pkt(1, 32, 1);
    wait_log(1, 20, "t6a");
    chk("t6_cnt_ff", 64'(eth_pkt_cnt), 64'hFFFF_FFFF);
    push_pkt(1, 33, 1);
    wait_log(2, 20, "t6b");
    chk("t6_cnt_wrap", 64'(eth_pkt_cnt), 64'h0);

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
